// File: rtl/frame_pattern_decoder_pkg.sv
// Shared constants for the frame pattern decoder: the float values it compares against,
// the pattern codes, the FSM state type and the result-encoding helper.
package frame_pattern_decoder_pkg;

    localparam int NUM_PATTERNS = 8;
    localparam int FRAME_WORDS  = 16;

    localparam logic [31:0] FP_0  = 32'h0000_0000;
    localparam logic [31:0] FP_1  = 32'h3F80_0000;
    localparam logic [31:0] FP_2  = 32'h4000_0000;
    localparam logic [31:0] FP_3  = 32'h4040_0000;
    localparam logic [31:0] FP_4  = 32'h4080_0000;
    localparam logic [31:0] FP_5  = 32'h40A0_0000;
    localparam logic [31:0] FP_6  = 32'h40C0_0000;
    localparam logic [31:0] FP_7  = 32'h40E0_0000;
    localparam logic [31:0] FP_8  = 32'h4100_0000;
    localparam logic [31:0] FP_9  = 32'h4110_0000;
    localparam logic [31:0] FP_10 = 32'h4120_0000;
    localparam logic [31:0] FP_11 = 32'h4130_0000;
    localparam logic [31:0] FP_12 = 32'h4140_0000;
    localparam logic [31:0] FP_13 = 32'h4150_0000;
    localparam logic [31:0] FP_14 = 32'h4160_0000;
    localparam logic [31:0] FP_15 = 32'h4170_0000;

    localparam logic [2:0] PAT_K0   = 3'd0;
    localparam logic [2:0] PAT_K1   = 3'd1;
    localparam logic [2:0] PAT_K2   = 3'd2;
    localparam logic [2:0] PAT_K3   = 3'd3;
    localparam logic [2:0] PAT_K4   = 3'd4;
    localparam logic [2:0] PAT_K5   = 3'd5;
    localparam logic [2:0] PAT_RAMP = 3'd6;
    localparam logic [2:0] PAT_SIX  = 3'd7;

    localparam logic [7:0] MASK_ALL = 8'hFF;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_RESULT  = 1'b1
    } state_t;

    // Exact single-precision encoding of the integer n (0..15).
    function automatic logic [31:0] fp_of_int(input logic [3:0] n);
        logic [31:0] v;
        case (n)
            4'd0:    v = FP_0;
            4'd1:    v = FP_1;
            4'd2:    v = FP_2;
            4'd3:    v = FP_3;
            4'd4:    v = FP_4;
            4'd5:    v = FP_5;
            4'd6:    v = FP_6;
            4'd7:    v = FP_7;
            4'd8:    v = FP_8;
            4'd9:    v = FP_9;
            4'd10:   v = FP_10;
            4'd11:   v = FP_11;
            4'd12:   v = FP_12;
            4'd13:   v = FP_13;
            4'd14:   v = FP_14;
            4'd15:   v = FP_15;
            default: v = FP_0;
        endcase
        return v;
    endfunction

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int b = 7; b >= 0; b--) begin
            if (m[b]) begin
                r = 3'(b);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_pattern_decoder_pattern_expect.sv
// Combinational lookup of the word pattern k expects at frame position i.
module pattern_expect
    import frame_pattern_decoder_pkg::*;
(
    input  logic [2:0]  i_k,
    input  logic [3:0]  i_idx,
    output logic [31:0] o_word
);

    // Constant patterns return float(k); the ramp returns float(i).
    always_comb begin
        o_word = FP_0;
        case (i_k)
            PAT_K0:   o_word = FP_0;
            PAT_K1:   o_word = FP_1;
            PAT_K2:   o_word = FP_2;
            PAT_K3:   o_word = FP_3;
            PAT_K4:   o_word = FP_4;
            PAT_K5:   o_word = FP_5;
            PAT_RAMP: o_word = fp_of_int(i_idx);
            PAT_SIX:  o_word = FP_6;
            default:  o_word = FP_0;
        endcase
    end

endmodule

// File: rtl/frame_pattern_decoder.sv
// Classifies 16-word float frames against eight fixed patterns using a candidate mask
// that is narrowed word by word; one registered result per frame with valid/ready output.
module frame_pattern_decoder
    import frame_pattern_decoder_pkg::*;
#(
    parameter int CHECK_LAST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_k,
    output logic        out_match,
    output logic        out_err_len
);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [7:0]  r_mask;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [2:0]  r_out_k;
    logic        r_out_match;
    logic        r_out_err_len;

    logic [31:0] w_exp [NUM_PATTERNS];
    logic [7:0]  w_hit;
    logic [7:0]  w_mask_next;
    logic        w_accept;
    logic        w_at_last_idx;
    logic        w_end;
    logic        w_len_err;
    logic        w_match;

    for (genvar k = 0; k < NUM_PATTERNS; k++) begin : g_expect
        pattern_expect u_expect (
            .i_k    (3'(k)),
            .i_idx  (r_idx),
            .o_word (w_exp[k])
        );
    end

    // Per-word compare, mask narrowing and frame-end / length-error decode.
    always_comb begin
        w_hit = 8'h00;
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            w_hit[k] = (in_data == w_exp[k]);
        end
        w_accept      = in_valid & r_in_ready;
        w_mask_next   = r_mask & w_hit;
        w_at_last_idx = (r_idx == 4'd15);
        if (CHECK_LAST != 0) begin
            w_end     = w_at_last_idx | in_last;
            w_len_err = w_at_last_idx ^ in_last;
        end else begin
            w_end     = w_at_last_idx;
            w_len_err = 1'b0;
        end
        w_match = (w_mask_next != 8'h00) & ~w_len_err;
    end

    // Collect/result FSM; the last word's compare feeds the result register directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_COLLECT;
            r_idx         <= 4'd0;
            r_mask        <= MASK_ALL;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_k       <= 3'd0;
            r_out_match   <= 1'b0;
            r_out_err_len <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        if (w_end) begin
                            r_state       <= ST_RESULT;
                            r_idx         <= 4'd0;
                            r_mask        <= MASK_ALL;
                            r_in_ready    <= 1'b0;
                            r_out_valid   <= 1'b1;
                            r_out_match   <= w_match;
                            r_out_err_len <= w_len_err;
                            r_out_k       <= w_match ? lowest_set(w_mask_next) : 3'd0;
                        end else begin
                            r_idx  <= r_idx + 4'd1;
                            r_mask <= w_mask_next;
                        end
                    end else begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        r_state       <= ST_COLLECT;
                        r_idx         <= 4'd0;
                        r_mask        <= MASK_ALL;
                        r_in_ready    <= 1'b1;
                        r_out_valid   <= 1'b0;
                        r_out_k       <= 3'd0;
                        r_out_match   <= 1'b0;
                        r_out_err_len <= 1'b0;
                    end else begin
                        r_state <= ST_RESULT;
                    end
                end
                default: begin
                    r_state       <= ST_COLLECT;
                    r_idx         <= 4'd0;
                    r_mask        <= MASK_ALL;
                    r_in_ready    <= 1'b1;
                    r_out_valid   <= 1'b0;
                    r_out_k       <= 3'd0;
                    r_out_match   <= 1'b0;
                    r_out_err_len <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_k       = r_out_k;
    assign out_match   = r_out_match;
    assign out_err_len = r_out_err_len;

endmodule

// File: doc/frame_pattern_decoder.md
FRAME_PATTERN_DECODER -- requirements
Module: frame_pattern_decoder

Interface
REQ-001 SHALL have parameter: CHECK_LAST, default 1, 1 = in_last framing enforced; 0 = in_last ignored, frame ends after 16th word.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  in  1  in_data/in_last valid.
REQ-005 SHALL have port: in_ready  out  1  block accepts a word this cycle.
REQ-006 SHALL have port: in_data  in  32  IEEE-754 single-precision sample x[i], i = 0..15 in order.
REQ-007 SHALL have port: in_last  in  1  marks final word of frame.
REQ-008 SHALL have port: out_valid  out  1  classification result available.
REQ-009 SHALL have port: out_ready  in  1  consumer takes result.
REQ-010 SHALL have port: out_k  out  3  decoded pattern code.
REQ-011 SHALL have port: out_match  out  1  frame matched exactly one defined pattern.
REQ-012 SHALL have port: out_err_len  out  1  frame length error.

Function
REQ-013 SHALL classify 16-word frames against 8 patterns: k=0..5 all words = float(k); k=6 ramp x[i] = float(i); k=7 all words = 6.0.
REQ-014 SHALL compare bit-exact on 32 bits; -0.0 (0x80000000) SHALL NOT match 0.0.
REQ-015 SHALL keep 8-bit candidate mask, set to all ones at frame start; each accepted word at index i SHALL clear bit k where in_data != expected(k,i).
REQ-016 SHALL use a 4-bit word index, incremented per accepted word (in_valid & in_ready), cleared at frame end.
REQ-017 SHALL use FSM states COLLECT and RESULT; COLLECT: in_ready=1, out_valid=0; RESULT: in_ready=0, out_valid=1.
REQ-018 SHALL move COLLECT->RESULT on acceptance of index 15, or on acceptance of in_last (CHECK_LAST=1); out_valid SHALL rise the cycle after that word.
REQ-019 SHALL compute out_match = final mask nonzero with no length error; out_k = index of lowest set bit, 0 when no match.
REQ-020 SHALL set out_err_len=1, out_match=0, out_k=0 when CHECK_LAST=1 and in_last arrives at index != 15, or index 15 arrives without in_last; the frame ends at that word either way.
REQ-021 SHALL hold out_k/out_match/out_err_len stable while out_valid=1 and out_ready=0.
REQ-022 SHALL move RESULT->COLLECT on out_valid & out_ready, resetting mask to all ones and index to 0; the next word is accepted no earlier than the following cycle.
REQ-023 SHALL include the final word's comparison in the reported mask (combinational mask update feeding result register).

Reset
REQ-024 SHALL, on rst, asynchronously enter COLLECT, index=0, mask=8'hFF, out_valid=0, out_k=0, out_match=0, out_err_len=0, in_ready=1 once released.
REQ-025 SHALL discard any partial frame on reset mid-frame; a partial result SHALL NOT be emitted.

Structure
REQ-026 SHALL place in shared package: float constants 0.0..15.0 (0x00000000, 0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000, 0x40E00000, 0x41000000 ... 0x41700000), pattern code constants, state typedef.
REQ-027 SHALL use one sub-module, pattern_expect: combinational (k, i) -> expected 32-bit word, instantiated 8 times.

Verification
REQ-028 SHALL cover: 16 words 0x40400000, in_last on word 15 -> out_valid next cycle, out_k=3, out_match=1, out_err_len=0.
REQ-029 SHALL cover: ramp 0x00000000, 0x3F800000 ... 0x41700000 -> out_k=6, out_match=1; all 0x40C00000 -> out_k=7.
REQ-030 SHALL cover: all-zero frame with word 9 = 0x80000000 -> out_match=0, out_k=0, out_err_len=0.
REQ-031 SHALL cover: in_last on word 7 (CHECK_LAST=1) -> result after word 7, out_err_len=1, out_match=0; with CHECK_LAST=0, same stimulus -> frame continues to 16 words.
REQ-032 SHALL cover: out_ready held low 5 cycles -> in_ready=0 and result stable throughout; then rst asserted after 10 words of a new frame -> out_valid=0, fresh all-2.0 frame yields out_k=2.
